dqsw_lane_training_ctrl: RTL and testbench

//  Parametrised DDR3 write-levelling controller for NUM_LANES DQSW IOD lanes.
//  Per lane, it sweeps the IOD dynamic delay line upward and majority-samples the DRAM write-levelling feedback.
//  It locks the first tap where feedback changes from 0 to 1, and reports the per-lane tap and pass/fail.

---
 rtl/dqsw_train_pkg.sv | 25 ++
 rtl/dqsw_sample_accum.sv | 74 +++++++
 rtl/dqsw_lane_training_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_dqsw_lane_training_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dqsw_train_pkg.sv
// rtl/dqsw_train_pkg.sv - shared types and helpers for DQSW write-levelling training
package dqsw_train_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_STEP,
        ST_NEXT,
        ST_DONE
    } train_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETTLE,
        PH_SAMPLE
    } accum_phase_t;

    function automatic int tap_width(input int tap_max);
        return (tap_max < 1) ? 1 : $clog2(tap_max + 1);
    endfunction

endpackage

// File: rtl/dqsw_sample_accum.sv
// rtl/dqsw_sample_accum.sv - settle wait then majority vote over a window of feedback samples
module dqsw_sample_accum
    import dqsw_train_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_COUNT  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic feedback,
    output logic settle_last,
    output logic sample_last,
    output logic valid,
    output logic majority
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ONES_W  = $clog2(SAMPLE_COUNT + 1);
    localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_END = CNT_W'(SAMPLE_COUNT - 1);
    localparam logic [ONES_W:0]   HALF_REF   = (ONES_W + 1)'(SAMPLE_COUNT);

    accum_phase_t      phase_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ONES_W-1:0] ones_q;
    logic [ONES_W-1:0] ones_next;

    assign settle_last = (phase_q == PH_SETTLE) && (cnt_q == SETTLE_END);
    assign sample_last = (phase_q == PH_SAMPLE) && (cnt_q == SAMPLE_END);
    assign ones_next   = ones_q + ONES_W'(feedback);

    // Strict majority: 2*ones > SAMPLE_COUNT, so a tie counts as 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_IDLE;
            cnt_q    <= '0;
            ones_q   <= '0;
            valid    <= 1'b0;
            majority <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                phase_q <= PH_SETTLE;
                cnt_q   <= '0;
                ones_q  <= '0;
            end else begin
                case (phase_q)
                    PH_SETTLE: begin
                        if (settle_last) begin
                            phase_q <= PH_SAMPLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    PH_SAMPLE: begin
                        ones_q <= ones_next;
                        if (sample_last) begin
                            phase_q  <= PH_IDLE;
                            valid    <= 1'b1;
                            majority <= ({ones_next, 1'b0} > HALF_REF);
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: phase_q <= PH_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/dqsw_lane_training_ctrl.sv
// rtl/dqsw_lane_training_ctrl.sv - sequential per-lane DDR3 write-levelling sweep over DQSW IOD delay lines
module dqsw_lane_training_ctrl
    import dqsw_train_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int TAP_MAX       = 127,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_COUNT  = 4,
    parameter int TAP_W         = tap_width(TAP_MAX)
) (
    input  logic                       FAB_CLK,
    input  logic                       ARST,
    input  logic                       START,
    input  logic [NUM_LANES-1:0]       LANE_MASK,
    input  logic [NUM_LANES-1:0]       WL_FEEDBACK,
    input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
    output logic                       BUSY,
    output logic                       TRAIN_DONE,
    output logic [NUM_LANES-1:0]       LANE_ERR,
    output logic [NUM_LANES*TAP_W-1:0] LANE_TAP
);

    localparam int LANE_W = $clog2(NUM_LANES + 1);
    localparam int SEL_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAP_MAX);

    train_state_t      state_q, state_d;
    logic [LANE_W-1:0] lane_q;
    logic [SEL_W-1:0]  lane_sel;
    logic [TAP_W-1:0]  tap_q;
    logic              seen_zero_q;
    logic [NUM_LANES-1:0] mask_q;
    logic [NUM_LANES-1:0] err_q;
    logic [TAP_W-1:0]  tap_res_q [NUM_LANES];

    logic              found;
    logic [LANE_W-1:0] found_lane;
    logic              accept, lock, lock_err, mark_zero, step, accum_start;
    logic [TAP_W-1:0]  lock_tap;
    logic              fb_sel, oor_sel;
    logic              settle_last, sample_last, accum_valid, majority;

    assign lane_sel = lane_q[SEL_W-1:0];
    assign fb_sel   = WL_FEEDBACK[lane_sel];
    assign oor_sel  = DELAY_LINE_OUT_OF_RANGE[lane_sel];
    assign LANE_ERR = err_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_tap_out
        assign LANE_TAP[g*TAP_W +: TAP_W] = tap_res_q[g];
    end

    dqsw_sample_accum #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .SAMPLE_COUNT (SAMPLE_COUNT)
    ) u_accum (
        .clk        (FAB_CLK),
        .rst        (ARST),
        .start      (accum_start),
        .feedback   (fb_sel),
        .settle_last(settle_last),
        .sample_last(sample_last),
        .valid      (accum_valid),
        .majority   (majority)
    );

    // Lowest unmasked lane at or above the current index; descending loop lets the lowest win.
    always_comb begin
        found      = 1'b0;
        found_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (!mask_q[i] && (LANE_W'(i) >= lane_q)) begin
                found      = 1'b1;
                found_lane = LANE_W'(i);
            end
        end
    end

    always_comb begin
        state_d              = state_q;
        accept               = 1'b0;
        lock                 = 1'b0;
        lock_err             = 1'b0;
        lock_tap             = tap_q;
        mark_zero            = 1'b0;
        step                 = 1'b0;
        accum_start          = 1'b0;
        DELAY_LINE_MOVE      = '0;
        DELAY_LINE_DIRECTION = '0;
        DELAY_LINE_LOAD      = '0;
        BUSY                 = 1'b0;
        TRAIN_DONE           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    accept  = 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                BUSY    = 1'b1;
                state_d = found ? ST_LOAD : ST_DONE;
            end
            ST_LOAD: begin
                BUSY                      = 1'b1;
                DELAY_LINE_LOAD[lane_sel] = 1'b1;
                accum_start               = 1'b1;
                state_d                   = ST_SETTLE;
            end
            ST_SETTLE: begin
                BUSY = 1'b1;
                if (settle_last) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                BUSY = 1'b1;
                if (sample_last) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                BUSY = 1'b1;
                if (accum_valid) begin
                    if (oor_sel) begin
                        lock     = 1'b1;
                        lock_err = 1'b1;
                        state_d  = ST_NEXT;
                    end else if (majority && seen_zero_q) begin
                        lock    = 1'b1;
                        state_d = ST_NEXT;
                    end else begin
                        // A high reading before any low one is not an edge; keep sweeping.
                        mark_zero = !majority;
                        if (tap_q == TAP_LAST) begin
                            lock     = 1'b1;
                            lock_err = 1'b1;
                            lock_tap = TAP_LAST;
                            state_d  = ST_NEXT;
                        end else begin
                            state_d = ST_STEP;
                        end
                    end
                end
            end
            ST_STEP: begin
                BUSY                           = 1'b1;
                DELAY_LINE_MOVE[lane_sel]      = 1'b1;
                DELAY_LINE_DIRECTION[lane_sel] = 1'b1;
                accum_start                    = 1'b1;
                step                           = 1'b1;
                state_d                        = ST_SETTLE;
            end
            ST_DONE: begin
                TRAIN_DONE = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            tap_q       <= '0;
            seen_zero_q <= 1'b0;
            mask_q      <= '0;
            err_q       <= '0;
            for (int i = 0; i < NUM_LANES; i++) tap_res_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mask_q <= LANE_MASK;
                err_q  <= '0;
                lane_q <= '0;
                for (int i = 0; i < NUM_LANES; i++) tap_res_q[i] <= '0;
            end
            if ((state_q == ST_NEXT) && found) lane_q <= found_lane;
            if (state_q == ST_LOAD) begin
                tap_q       <= '0;
                seen_zero_q <= 1'b0;
            end
            if (step) tap_q <= tap_q + TAP_W'(1);
            if (mark_zero) seen_zero_q <= 1'b1;
            if (lock) begin
                err_q[lane_sel]     <= lock_err;
                tap_res_q[lane_sel] <= lock_tap;
                lane_q              <= lane_q + LANE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dqsw_lane_training_ctrl.sv
// tb/tb_dqsw_lane_training_ctrl.sv - directed self-checking bench for dqsw_lane_training_ctrl
module tb_dqsw_lane_training_ctrl;

    logic        FAB_CLK = 1'b0;
    logic        ARST;
    logic        START;
    logic [3:0]  LANE_MASK;
    logic [3:0]  WL_FEEDBACK;
    logic [3:0]  DELAY_LINE_OUT_OF_RANGE;
    logic [3:0]  DELAY_LINE_MOVE;
    logic [3:0]  DELAY_LINE_DIRECTION;
    logic [3:0]  DELAY_LINE_LOAD;
    logic        BUSY;
    logic        TRAIN_DONE;
    logic [3:0]  LANE_ERR;
    logic [27:0] LANE_TAP;

    int checks = 0;
    int failures = 0;

    // DRAM/IOD model: per-lane tap follows LOAD/MOVE, feedback is a function of that tap.
    int  kind [4];
    int  edge_tap [4];
    int  oor_at [4];
    int  model_tap [4];
    int  move_cnt [4];
    int  load_cnt [4];
    int  done_cnt = 0;
    int  onehot_bad = 0;
    int  dir_bad = 0;
    logic tgl = 1'b0;

    dqsw_lane_training_ctrl dut (
        .FAB_CLK                (FAB_CLK),
        .ARST                   (ARST),
        .START                  (START),
        .LANE_MASK              (LANE_MASK),
        .WL_FEEDBACK            (WL_FEEDBACK),
        .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
        .DELAY_LINE_MOVE        (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION   (DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD        (DELAY_LINE_LOAD),
        .BUSY                   (BUSY),
        .TRAIN_DONE             (TRAIN_DONE),
        .LANE_ERR               (LANE_ERR),
        .LANE_TAP               (LANE_TAP)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    function automatic logic fb_of(input int k, input int e, input int tap, input logic t);
        case (k)
            0:       return (tap >= e);
            1:       return 1'b0;
            2:       return (tap <= 4) || (tap >= 9);
            default: return (tap >= e) ? 1'b1 : t;
        endcase
    endfunction

    always_comb begin
        WL_FEEDBACK             = '0;
        DELAY_LINE_OUT_OF_RANGE = '0;
        for (int i = 0; i < 4; i++) begin
            WL_FEEDBACK[i]             = fb_of(kind[i], edge_tap[i], model_tap[i], tgl);
            DELAY_LINE_OUT_OF_RANGE[i] = (model_tap[i] >= oor_at[i]);
        end
    end

    always @(negedge FAB_CLK) begin
        tgl <= ~tgl;
        if (($countones(DELAY_LINE_MOVE) + $countones(DELAY_LINE_LOAD)) > 1) onehot_bad <= onehot_bad + 1;
        if (DELAY_LINE_DIRECTION !== DELAY_LINE_MOVE) dir_bad <= dir_bad + 1;
        if (TRAIN_DONE) done_cnt <= done_cnt + 1;
        for (int i = 0; i < 4; i++) begin
            if (DELAY_LINE_LOAD[i]) begin
                model_tap[i] <= 0;
                load_cnt[i]  <= load_cnt[i] + 1;
            end
            if (DELAY_LINE_MOVE[i]) begin
                model_tap[i] <= model_tap[i] + 1;
                move_cnt[i]  <= move_cnt[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input int k, input int e, input int oor);
        kind[i]     = k;
        edge_tap[i] = e;
        oor_at[i]   = oor;
    endtask

    task automatic default_lanes();
        set_lane(0, 0, 10, 1000);
        set_lane(1, 0, 20, 1000);
        set_lane(2, 0, 30, 1000);
        set_lane(3, 0, 40, 1000);
    endtask

    task automatic run_train(input logic [3:0] mask);
        int cyc;
        LANE_MASK = mask;
        START     = 1'b1;
        @(negedge FAB_CLK);
        START = 1'b0;
        cyc   = 0;
        while (!TRAIN_DONE && cyc < 10000) begin
            @(negedge FAB_CLK);
            cyc++;
        end
        check("done_within_budget", 64'(cyc < 10000), 64'd1);
        repeat (2) @(negedge FAB_CLK);
    endtask

    initial begin
        int mv [4];
        int ld [4];
        int dc;
        ARST      = 1'b1;
        START     = 1'b0;
        LANE_MASK = '0;
        default_lanes();

        // Reset state
        repeat (3) @(negedge FAB_CLK);
        check("rst_strobes", {DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD}, 64'd0);
        check("rst_status", {BUSY, TRAIN_DONE, LANE_ERR}, 64'd0);
        check("rst_tap", LANE_TAP, 64'd0);
        ARST = 1'b0;
        @(negedge FAB_CLK);
        check("idle_busy", BUSY, 64'd0);

        // 1: edges at 10/20/30/40
        for (int i = 0; i < 4; i++) begin mv[i] = move_cnt[i]; ld[i] = load_cnt[i]; end
        dc = done_cnt;
        run_train(4'b0000);
        check("t1_tap", LANE_TAP, {7'd40, 7'd30, 7'd20, 7'd10});
        check("t1_err", LANE_ERR, 64'd0);
        check("t1_done_pulses", done_cnt - dc, 64'd1);
        check("t1_busy_after", BUSY, 64'd0);
        check("t1_moves_l0", move_cnt[0] - mv[0], 64'd10);
        check("t1_moves_l3", move_cnt[3] - mv[3], 64'd40);
        check("t1_loads_l2", load_cnt[2] - ld[2], 64'd1);

        // 2: lane 1 stuck at 0
        set_lane(1, 1, 0, 1000);
        mv[1] = move_cnt[1];
        run_train(4'b0000);
        check("t2_err", LANE_ERR, 64'b0010);
        check("t2_tap", LANE_TAP, {7'd40, 7'd30, 7'd127, 7'd10});
        check("t2_moves_l1", move_cnt[1] - mv[1], 64'd127);

        // 3: lane 0 high at taps 0-4, low 5-8, high from 9
        default_lanes();
        set_lane(0, 2, 0, 1000);
        mv[0] = move_cnt[0];
        run_train(4'b0000);
        check("t3_tap", LANE_TAP, {7'd40, 7'd30, 7'd20, 7'd9});
        check("t3_err", LANE_ERR, 64'd0);
        check("t3_moves_l0", move_cnt[0] - mv[0], 64'd9);

        // 4: lane 2 out of range from tap 50
        default_lanes();
        set_lane(2, 0, 60, 50);
        mv[2] = move_cnt[2];
        run_train(4'b0000);
        check("t4_err", LANE_ERR, 64'b0100);
        check("t4_tap", LANE_TAP, {7'd40, 7'd50, 7'd20, 7'd10});
        check("t4_moves_l2", move_cnt[2] - mv[2], 64'd50);

        // 5: masked lanes, then all masked
        default_lanes();
        for (int i = 0; i < 4; i++) begin mv[i] = move_cnt[i]; ld[i] = load_cnt[i]; end
        run_train(4'b1010);
        check("t5_tap", LANE_TAP, {7'd0, 7'd30, 7'd0, 7'd10});
        check("t5_err", LANE_ERR, 64'd0);
        check("t5_l1_strobes", (move_cnt[1] - mv[1]) + (load_cnt[1] - ld[1]), 64'd0);
        check("t5_l3_strobes", (move_cnt[3] - mv[3]) + (load_cnt[3] - ld[3]), 64'd0);
        LANE_MASK = 4'hF;
        START     = 1'b1;
        @(negedge FAB_CLK);
        START = 1'b0;
        check("t5_c2_busy", BUSY, 64'd1);
        check("t5_c2_done", TRAIN_DONE, 64'd0);
        @(negedge FAB_CLK);
        check("t5_c3_done", TRAIN_DONE, 64'd1);
        check("t5_c3_busy", BUSY, 64'd0);
        @(negedge FAB_CLK);
        check("t5_c4_done", TRAIN_DONE, 64'd0);
        check("t5_cleared_tap", LANE_TAP, 64'd0);

        // 6: START while busy is ignored, ARST mid-sweep, clean retrain
        default_lanes();
        LANE_MASK = 4'b0000;
        START     = 1'b1;
        @(negedge FAB_CLK);
        START = 1'b0;
        repeat (40) @(negedge FAB_CLK);
        LANE_MASK = 4'hF;
        START     = 1'b1;
        @(negedge FAB_CLK);
        START     = 1'b0;
        LANE_MASK = 4'b0000;
        check("t6_busy_ignore", BUSY, 64'd1);
        repeat (210) @(negedge FAB_CLK);
        check("t6_mid_l0_tap", LANE_TAP[6:0], 64'd10);
        check("t6_mid_busy", BUSY, 64'd1);
        ARST = 1'b1;
        @(negedge FAB_CLK);
        check("t6_arst_outputs", {DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, BUSY, TRAIN_DONE, LANE_ERR}, 64'd0);
        check("t6_arst_tap", LANE_TAP, 64'd0);
        for (int i = 0; i < 4; i++) begin mv[i] = move_cnt[i]; ld[i] = load_cnt[i]; end
        repeat (2) @(negedge FAB_CLK);
        ARST = 1'b0;
        repeat (20) @(negedge FAB_CLK);
        check("t6_quiet_after_arst",
              (move_cnt[0] - mv[0]) + (move_cnt[1] - mv[1]) + (move_cnt[2] - mv[2]) + (move_cnt[3] - mv[3]) +
              (load_cnt[0] - ld[0]) + (load_cnt[1] - ld[1]) + (load_cnt[2] - ld[2]) + (load_cnt[3] - ld[3]), 64'd0);
        check("t6_idle_busy", BUSY, 64'd0);
        run_train(4'b0000);
        check("t6_retrain_tap", LANE_TAP, {7'd40, 7'd30, 7'd20, 7'd10});
        check("t6_retrain_err", LANE_ERR, 64'd0);

        // 7: 2-of-4 ones is a tie and reads as 0; edge at tap 5 on lane 3 only
        set_lane(3, 3, 5, 1000);
        run_train(4'b0111);
        check("t7_tap", LANE_TAP, {7'd5, 21'd0});
        check("t7_err", LANE_ERR, 64'd0);

        check("onehot_strobes", onehot_bad, 64'd0);
        check("direction_matches_move", dir_bad, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
